char_tile_buffer: RTL and testbench



---
 rtl/char_tile_pkg.sv | 21 ++
 rtl/char_tile_buffer_if.sv | 13 +
 rtl/char_tile_ram.sv | 28 ++
 rtl/char_tile_buffer.sv | 103 ++++++++++
 tb/tb_char_tile_buffer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/char_tile_pkg.sv
// Shared types, defaults and helpers for the character tile buffer.
package char_tile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int unsigned DEF_COLS   = 16;
  localparam int unsigned DEF_ROWS   = 16;
  localparam int unsigned DEF_CODE_W = 7;
  localparam logic [DEF_CODE_W-1:0] DEF_BLANK_CODE = 7'h20;

  // Row-major cell index: {row, col} with col occupying the low col_w bits.
  function automatic int unsigned pack_xy(input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned col_w);
    return (row << col_w) | col;
  endfunction

endpackage

// File: rtl/char_tile_buffer_if.sv
// Valid/ready write port used by game logic to update text-grid cells.
interface char_tile_buffer_if #(
  parameter int unsigned XY_W   = 8,
  parameter int unsigned CODE_W = 7
);
  logic              wr_valid;
  logic              wr_ready;
  logic [XY_W-1:0]   wr_xy;
  logic [CODE_W-1:0] wr_code;

  modport master (output wr_valid, output wr_xy, output wr_code, input wr_ready);
  modport slave  (input wr_valid, input wr_xy, input wr_code, output wr_ready);
endinterface

// File: rtl/char_tile_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module char_tile_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned CODE_W = 7,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [CODE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [CODE_W-1:0] rdata
);

  logic [CODE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register reset only; array itself is never reset.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/char_tile_buffer.sv
// Writable COLS x ROWS character grid with clear sweep and registered read.
// Optional CHAR_TILE_AUTOINC_EN: writes go to an auto-incrementing cursor.
module char_tile_buffer
  import char_tile_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned CODE_W = DEF_CODE_W,
  parameter logic [CODE_W-1:0] BLANK_CODE = DEF_BLANK_CODE,
  localparam int unsigned COL_W = $clog2(COLS),
  localparam int unsigned ROW_W = $clog2(ROWS),
  localparam int unsigned XY_W  = COL_W + ROW_W,
  localparam int unsigned DEPTH = COLS * ROWS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XY_W-1:0]   rd_xy,
  output logic [CODE_W-1:0] char_code,
  char_tile_buffer_if.slave wr,
  input  logic              clr_req,
  output logic              busy
`ifdef CHAR_TILE_AUTOINC_EN
  ,
  input  logic              cur_load,
  input  logic [XY_W-1:0]   cur_xy
`endif
);

  localparam logic [XY_W-1:0] LAST_CELL = XY_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [XY_W-1:0]   clr_cnt;
  logic              wr_accept;
  logic [XY_W-1:0]   wr_addr;
  logic              ram_we;
  logic [XY_W-1:0]   ram_waddr;
  logic [CODE_W-1:0] ram_wdata;

  assign busy        = (state == CLEAR);
  assign wr.wr_ready = (state == IDLE);
  assign wr_accept   = wr.wr_valid && wr.wr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == LAST_CELL) state_nxt = IDLE;
      IDLE:    if (clr_req) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

`ifdef CHAR_TILE_AUTOINC_EN
  logic [XY_W-1:0] cursor;

  // A write in the same cycle as cur_load uses the cursor value before the load.
  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) cursor <= '0;
    else if (cur_load)         cursor <= cur_xy;
    else if (wr_accept)        cursor <= cursor + 1'b1;
  end

  assign wr_addr = cursor;
`else
  assign wr_addr = wr.wr_xy;
`endif

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr.wr_code;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = BLANK_CODE;
    end else if (wr_accept) begin
      ram_we    = 1'b1;
    end
  end

  char_tile_ram #(
    .DEPTH  (DEPTH),
    .CODE_W (CODE_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_xy),
    .rdata (char_code)
  );

endmodule

// File: tb/tb_char_tile_buffer.sv
// Scoreboard bench for char_tile_buffer at default 16x16 geometry.
module tb_char_tile_buffer;
  import char_tile_pkg::*;

  localparam int unsigned XY_W   = 8;
  localparam int unsigned CODE_W = 7;
  localparam int unsigned NCELLS = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [XY_W-1:0]   rd_xy = '0;
  logic [CODE_W-1:0] char_code;
  logic              clr_req = 1'b0;
  logic              busy;
`ifdef CHAR_TILE_AUTOINC_EN
  logic              cur_load = 1'b0;
  logic [XY_W-1:0]   cur_xy = '0;
`endif

  char_tile_buffer_if #(.XY_W(XY_W), .CODE_W(CODE_W)) wr_bus ();

  char_tile_buffer #(
    .COLS       (16),
    .ROWS       (16),
    .CODE_W     (7),
    .BLANK_CODE (7'h20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_xy     (rd_xy),
    .char_code (char_code),
    .wr        (wr_bus.slave),
    .clr_req   (clr_req),
    .busy      (busy)
`ifdef CHAR_TILE_AUTOINC_EN
    ,
    .cur_load  (cur_load),
    .cur_xy    (cur_xy)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [CODE_W-1:0] exp_q[$];
  string             name_q[$];
  logic              rd_issue = 1'b0;
  logic              rd_chk = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one registered read result per issued read.
  always @(posedge clk) rd_chk <= rd_issue;

  always @(negedge clk) begin
    if (rd_chk) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected: got 0x%0h, want no read", char_code);
      end else begin
        automatic logic [CODE_W-1:0] e = exp_q.pop_front();
        automatic string n = name_q.pop_front();
        if (char_code !== e) begin
          miscompares++;
          $display("FAIL %s: char_code 0x%0h, want 0x%0h", n, char_code, e);
        end
      end
    end
  end

  task automatic read_expect(input logic [XY_W-1:0] xy, input logic [CODE_W-1:0] e,
                             input string name);
    @(negedge clk);
    rd_xy    = xy;
    rd_issue = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic read_end();
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic read_all_blank(input string name);
    for (int i = 0; i < NCELLS; i++) read_expect(XY_W'(i), 7'h20, name);
    read_end();
  endtask

  task automatic write_cell(input logic [XY_W-1:0] xy, input logic [CODE_W-1:0] code);
`ifdef CHAR_TILE_AUTOINC_EN
    @(negedge clk);
    cur_load = 1'b1;
    cur_xy   = xy;
    @(negedge clk);
    cur_load = 1'b0;
`else
    @(negedge clk);
`endif
    check("wr_ready_idle", int'(wr_bus.wr_ready), 1);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_xy    = xy;
    wr_bus.wr_code  = code;
    @(negedge clk);
    wr_bus.wr_valid = 1'b0;
  endtask

  // Counts posedges until busy drops; caller starts with busy already high.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_xy    = '0;
    wr_bus.wr_code  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 1);
    check("rst_wr_ready", int'(wr_bus.wr_ready), 0);
    check("rst_char_code", int'(char_code), 0);

    // Power-up sweep length
    rst = 1'b0;
    count_busy(cnt);
    check("sweep_len_after_rst", cnt, 256);
    check("wr_ready_after_sweep", int'(wr_bus.wr_ready), 1);
    read_all_blank("blank_after_reset");

    // Single write at row 3, col 5 plus neighbours untouched
    write_cell(XY_W'(pack_xy(3, 5, 4)), 7'h38);
    read_expect(8'h35, 7'h38, "rd_r3c5");
    read_expect(8'h34, 7'h20, "rd_r3c4");
    read_expect(8'h36, 7'h20, "rd_r3c6");
    read_expect(8'h25, 7'h20, "rd_r2c5");
    read_expect(8'h45, 7'h20, "rd_r4c5");
    read_end();

    // Same-cell read and write: read-first
`ifdef CHAR_TILE_AUTOINC_EN
    @(negedge clk);
    cur_load = 1'b1;
    cur_xy   = 8'h00;
    @(negedge clk);
    cur_load = 1'b0;
`else
    @(negedge clk);
`endif
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_xy    = 8'h00;
    wr_bus.wr_code  = 7'h41;
    rd_xy           = 8'h00;
    rd_issue        = 1'b1;
    exp_q.push_back(7'h20);
    name_q.push_back("rw_same_old");
    @(negedge clk);
    wr_bus.wr_valid = 1'b0;
    exp_q.push_back(7'h41);
    name_q.push_back("rw_same_new");
    read_end();

    // Clear request together with a write; writes held off during sweep
    @(negedge clk);
    clr_req         = 1'b1;
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_xy    = 8'h10;
    wr_bus.wr_code  = 7'h55;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    cnt = 0;
    while (!wr_bus.wr_ready && cnt < 1000) begin
      clr_req        = (cnt == 50);
      wr_bus.wr_xy   = XY_W'(cnt);
      wr_bus.wr_code = 7'h7F;
      @(posedge clk);
      #1;
      cnt++;
    end
    wr_bus.wr_valid = 1'b0;
    clr_req         = 1'b0;
    check("clr_ready_low_len", cnt, 256);
    check("clr_busy_done", int'(busy), 0);
    read_all_blank("blank_after_clear");

    // Reset asserted mid-sweep restarts it
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (99) @(negedge clk);
    check("busy_mid_sweep", int'(busy), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("busy_in_rst", int'(busy), 1);
    rst = 1'b0;
    count_busy(cnt);
    check("sweep_len_after_midrst", cnt, 256);
    read_all_blank("blank_after_midrst");

`ifdef CHAR_TILE_AUTOINC_EN
    // Cursor load then auto-increment across the last cell
    @(negedge clk);
    cur_load = 1'b1;
    cur_xy   = 8'hFE;
    @(negedge clk);
    cur_load = 1'b0;
    wr_bus.wr_xy   = 8'h77;
    wr_bus.wr_code = 7'h31;
    for (int i = 0; i < 3; i++) begin
      wr_bus.wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_code  = 7'h32;
    wr_bus.wr_valid = 1'b1;
    @(negedge clk);
    wr_bus.wr_valid = 1'b0;
    read_expect(8'hFE, 7'h31, "ainc_fe");
    read_expect(8'hFF, 7'h31, "ainc_ff");
    read_expect(8'h00, 7'h31, "ainc_00");
    read_expect(8'h01, 7'h32, "ainc_cursor_01");
    read_expect(8'h77, 7'h20, "ainc_wr_xy_ignored");
    read_end();
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
